// File: rtl/fib_hit_counter.sv
// fib_hit_counter: counts recognised Fibonacci digits in two-digit BCD,
// tracks current/longest run of consecutive hits and the last hit digit.
module fib_hit_counter #(
    parameter bit SATURATE   = 1'b1,
    parameter bit MAX_RUN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [3:0] bcd,
    input  logic       fib,
    input  logic       clear,
    output logic [7:0] hit_count,
    output logic [7:0] run_max,
    output logic [3:0] last_fib,
    output logic       ovf,
    output logic       full,
    output logic       bad
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FULL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic [7:0] run_q, run_d;
    logic [7:0] run_max_q, run_max_d;
    logic [3:0] last_fib_q, last_fib_d;
    logic       ovf_q, ovf_d;
    logic       full_q, full_d;
    logic       bad_q, bad_d;

    // Two-digit BCD increment, wrapping 99 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Next-state: clear wins over valid; bad samples only raise the pulse.
    always_comb begin
        state_d     = state_q;
        hit_count_d = hit_count_q;
        run_d       = run_q;
        run_max_d   = run_max_q;
        last_fib_d  = last_fib_q;
        ovf_d       = 1'b0;
        bad_d       = 1'b0;
        if (clear) begin
            state_d     = ST_IDLE;
            hit_count_d = '0;
            run_d       = '0;
            run_max_d   = '0;
            last_fib_d  = '0;
        end else if (valid) begin
            if (bcd > 4'd9) begin
                bad_d = 1'b1;
            end else if (state_q != ST_FULL) begin
                if (fib) begin
                    last_fib_d = bcd;
                    state_d    = ST_RUN;
                    run_d      = (run_q == 8'h99) ? run_q : bcd_inc(run_q);
                    if (MAX_RUN_EN && (run_d > run_max_q)) begin
                        run_max_d = run_d;
                    end
                    if (hit_count_q == 8'h99) begin
                        if (SATURATE) begin
                            state_d = ST_FULL;
                        end else begin
                            hit_count_d = '0;
                            ovf_d       = 1'b1;
                        end
                    end else begin
                        hit_count_d = bcd_inc(hit_count_q);
                    end
                end else begin
                    run_d   = '0;
                    state_d = ST_GAP;
                end
            end
        end
        full_d = (state_d == ST_FULL);
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hit_count_q <= '0;
            run_q       <= '0;
            run_max_q   <= '0;
            last_fib_q  <= '0;
            ovf_q       <= 1'b0;
            full_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_count_q <= hit_count_d;
            run_q       <= run_d;
            run_max_q   <= run_max_d;
            last_fib_q  <= last_fib_d;
            ovf_q       <= ovf_d;
            full_q      <= full_d;
            bad_q       <= bad_d;
        end
    end

    assign hit_count = hit_count_q;
    assign run_max   = MAX_RUN_EN ? run_max_q : 8'h00;
    assign last_fib  = last_fib_q;
    assign ovf       = ovf_q;
    assign full      = full_q;
    assign bad       = bad_q;

endmodule
